decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter WIDTH, default 4, select width; output width is 2**WIDTH.
REQ-002 Parameter DIV, default 5, scan step period in clock cycles; legal range 1..255.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  1 = decoder active; 0 = outputs forced idle.
REQ-006 Port mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-007 Port load  input  1  in scan modes, load binary_in into index.
REQ-008 Port binary_in  input  WIDTH  select value.
REQ-009 Port value  output  2**WIDTH  registered one-hot decode of index, or all zeros.
REQ-010 Port index  output  WIDTH  registered current select.
REQ-011 Port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-012 Block SHALL hold a state register with states IDLE, DIRECT, SCAN_UP, SCAN_DOWN, HOLD.
REQ-013 State transitions: enable=0 -> IDLE; enable=1 -> state selected by mode (00/01/10/11 -> DIRECT/SCAN_UP/SCAN_DOWN/HOLD), evaluated every cycle.
REQ-014 value SHALL equal 1<<index whenever state is not IDLE, and all zeros in IDLE; value and index update on the same edge (no extra latency between them).
REQ-015 DIRECT: index <= binary_in every cycle; value reflects binary_in one cycle after it is sampled.
REQ-016 SCAN_UP/SCAN_DOWN: prescaler counts 0..DIV-1; on the cycle prescaler==DIV-1, index steps +1 (UP) or -1 (DOWN) modulo 2**WIDTH and prescaler returns to 0.
REQ-017 DIV=1: index steps every cycle.
REQ-018 wrap SHALL pulse 1 for exactly one cycle, coincident with index update, when UP steps from 2**WIDTH-1 to 0 or DOWN steps from 0 to 2**WIDTH-1; 0 otherwise.
REQ-019 load=1 in SCAN_UP/SCAN_DOWN: index <= binary_in, prescaler <= 0, no step, wrap=0 that cycle; load has priority over step.
REQ-020 load SHALL be ignored in DIRECT, HOLD and IDLE.
REQ-021 HOLD: index and value held; prescaler held at 0.
REQ-022 Any change of state (mode change or enable edge) SHALL reset prescaler to 0 on that edge; first step after entering a scan state occurs DIV cycles after entry.
REQ-023 IDLE: index held at last value, prescaler 0, wrap 0, value 0; re-enabling in HOLD or scan mode resumes from held index.
REQ-024 All arithmetic on index is unsigned WIDTH-bit modulo 2**WIDTH.

Reset
REQ-025 reset=1 at a clock edge SHALL set state IDLE, index 0, value 0, wrap 0, prescaler 0, overriding all other inputs.
REQ-026 reset asserted mid-scan SHALL abort the scan; after release with enable=1, mode=01, first step to index 1 occurs DIV cycles later.
REQ-027 Outputs SHALL be defined (no X) from the first edge with reset=1.

Verification (WIDTH=4, DIV=5)
REQ-028 DIRECT, enable=1, binary_in=9 -> next cycle index=9, value=16'h0200, wrap=0.
REQ-029 SCAN_UP from index 14, 12 cycles -> index 15 after 5 cycles, 0 after 10 with wrap=1 for that single cycle; value=16'h0001.
REQ-030 SCAN_DOWN, load=1 with binary_in=0 on a step cycle -> index=0, no wrap; 5 cycles later index=15, wrap=1, value=16'h8000.
REQ-031 enable dropped during SCAN_UP at index 6 -> value=16'h0000, index stays 6; re-enable in HOLD -> value=16'h0040, index stays 6.
REQ-032 reset pulsed during SCAN_UP at index 11 -> index=0, value=0, wrap=0 next cycle; after release, index 1 appears 5 cycles later.
REQ-033 Parameter sweep WIDTH=2, DIV=1, SCAN_UP -> index 0,1,2,3,0 on consecutive cycles, wrap high on the 3->0 cycle only.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: one-hot decoder with direct, scanning and hold modes.
// Scan steps are paced by a prescaler; wrap pulses on roll-over.
module decoder_scan #(
   parameter int WIDTH = 4,
   parameter int DIV   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  load,
   input  logic [WIDTH-1:0]      binary_in,
   output logic [2**WIDTH-1:0]   value,
   output logic [WIDTH-1:0]      index,
   output logic                  wrap
);

   localparam int N = 2**WIDTH;
   localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIRECT,
      S_UP,
      S_DOWN,
      S_HOLD
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_index;
   logic [N-1:0]     r_value;
   logic             r_wrap;
   logic [7:0]       r_presc;

   state_t           w_next;
   logic             w_scan;
   logic             w_up;
   logic             w_changed;
   logic             w_load;
   logic             w_step;
   logic             w_wrap;
   logic [WIDTH-1:0] w_index;
   logic [7:0]       w_presc;
   logic [N-1:0]     w_onehot;

   // Next state follows enable and mode every cycle.
   always_comb begin
      w_next = S_IDLE;
      if (enable) begin
         case (mode)
            2'b00:   w_next = S_DIRECT;
            2'b01:   w_next = S_UP;
            2'b10:   w_next = S_DOWN;
            default: w_next = S_HOLD;
         endcase
      end
   end

   // A state change restarts pacing; load beats a pending step.
   always_comb begin
      w_scan    = (w_next == S_UP) || (w_next == S_DOWN);
      w_up      = (w_next == S_UP);
      w_changed = (w_next != r_state);
      w_load    = w_scan && load;
      w_step    = w_scan && !w_changed && !w_load &&
                  (r_presc == DIV_M1);
      w_index   = r_index;
      w_wrap    = 1'b0;
      if (w_next == S_DIRECT) begin
         w_index = binary_in;
      end else if (w_load) begin
         w_index = binary_in;
      end else if (w_step) begin
         if (w_up) begin
            w_index = r_index + WIDTH'(1);
            w_wrap  = (r_index == '1);
         end else begin
            w_index = r_index - WIDTH'(1);
            w_wrap  = (r_index == '0);
         end
      end
      if (!w_scan || w_changed || w_load || w_step)
         w_presc = 8'd0;
      else
         w_presc = r_presc + 8'd1;
      w_onehot = {{(N-1){1'b0}}, 1'b1} << w_index;
   end

   // State and all outputs registered on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_value <= '0;
         r_wrap  <= 1'b0;
         r_presc <= 8'd0;
      end else begin
         r_state <= w_next;
         r_index <= w_index;
         r_value <= (w_next == S_IDLE) ? '0 : w_onehot;
         r_wrap  <= w_wrap;
         r_presc <= w_presc;
      end
   end

   assign value = r_value;
   assign index = r_index;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed checks of decoder_scan.
// Second instance covers WIDTH=2, DIV=1.
module tb_decoder_scan;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  mode;
   logic        load;
   logic [3:0]  binary_in;
   logic [15:0] value;
   logic [3:0]  index;
   logic        wrap;

   logic        e2;
   logic [1:0]  m2;
   logic        l2;
   logic [1:0]  b2;
   logic [3:0]  v2;
   logic [1:0]  i2;
   logic        w2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decoder_scan #(.WIDTH(4), .DIV(5)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .load(load), .binary_in(binary_in),
      .value(value), .index(index), .wrap(wrap)
   );

   decoder_scan #(.WIDTH(2), .DIV(1)) u_dut2 (
      .clk(clk), .reset(reset), .enable(e2), .mode(m2),
      .load(l2), .binary_in(b2),
      .value(v2), .index(i2), .wrap(w2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; mode = 2'b01;
      load = 1'b1; binary_in = 4'd7;
      e2 = 1'b1; m2 = 2'b01; l2 = 1'b0; b2 = 2'd0;
      tick();
      tick();
      checks++;
      if (index !== 4'd0) begin
         failures++;
         $display("FAIL reset_index got=%0d exp=0", index);
      end
      checks++;
      if (value !== 16'h0000) begin
         failures++;
         $display("FAIL reset_value got=%h exp=0000", value);
      end
      checks++;
      if (wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset_wrap got=%b exp=0", wrap);
      end
      checks++;
      if (v2 !== 4'h0 || i2 !== 2'd0) begin
         failures++;
         $display("FAIL reset_dut2 got v=%h i=%0d exp v=0 i=0", v2, i2);
      end
      e2 = 1'b0;
      load = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_direct();
      enable = 1'b1; mode = 2'b00; binary_in = 4'd9;
      tick();
      checks++;
      if (index !== 4'd9 || value !== 16'h0200 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL direct_9 got i=%0d v=%h w=%b exp i=9 v=0200 w=0",
                  index, value, wrap);
      end
      binary_in = 4'd3; load = 1'b1;
      tick();
      checks++;
      if (index !== 4'd3 || value !== 16'h0008) begin
         failures++;
         $display("FAIL direct_3 got i=%0d v=%h exp i=3 v=0008",
                  index, value);
      end
      load = 1'b0;
   endtask

   task automatic test_scan_up();
      logic [3:0] ei;
      logic       ew;
      mode = 2'b01; load = 1'b1; binary_in = 4'd14;
      tick();
      checks++;
      if (index !== 4'd14 || value !== 16'h4000) begin
         failures++;
         $display("FAIL up_load got i=%0d v=%h exp i=14 v=4000",
                  index, value);
      end
      load = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         ei = (c < 5) ? 4'd14 : (c < 10) ? 4'd15 : 4'd0;
         ew = (c == 10);
         checks++;
         if (index !== ei || wrap !== ew) begin
            failures++;
            $display("FAIL up_cyc%0d got i=%0d w=%b exp i=%0d w=%b",
                     c, index, wrap, ei, ew);
         end
         if (c == 10) begin
            checks++;
            if (value !== 16'h0001) begin
               failures++;
               $display("FAIL up_wrap_value got=%h exp=0001", value);
            end
         end
      end
   endtask

   task automatic test_scan_down();
      mode = 2'b10;
      tick();
      for (int c = 0; c < 4; c++) tick();
      load = 1'b1; binary_in = 4'd0;
      tick();
      checks++;
      if (index !== 4'd0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL down_load got i=%0d w=%b exp i=0 w=0",
                  index, wrap);
      end
      load = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      checks++;
      if (index !== 4'd0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL down_wait got i=%0d w=%b exp i=0 w=0",
                  index, wrap);
      end
      tick();
      checks++;
      if (index !== 4'd15 || wrap !== 1'b1 || value !== 16'h8000) begin
         failures++;
         $display("FAIL down_wrap got i=%0d w=%b v=%h exp i=15 w=1 v=8000",
                  index, wrap, value);
      end
      tick();
      checks++;
      if (wrap !== 1'b0) begin
         failures++;
         $display("FAIL down_wrap_pulse got=%b exp=0", wrap);
      end
   endtask

   task automatic test_hold();
      mode = 2'b11; load = 1'b1; binary_in = 4'd3;
      for (int c = 0; c < 7; c++) tick();
      checks++;
      if (index !== 4'd15 || value !== 16'h8000 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL hold got i=%0d v=%h w=%b exp i=15 v=8000 w=0",
                  index, value, wrap);
      end
      load = 1'b0;
   endtask

   task automatic test_enable_drop();
      mode = 2'b01; load = 1'b1; binary_in = 4'd6;
      tick();
      load = 1'b0;
      tick();
      enable = 1'b0; load = 1'b1; binary_in = 4'd2;
      tick();
      checks++;
      if (value !== 16'h0000 || index !== 4'd6 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL idle got v=%h i=%0d w=%b exp v=0000 i=6 w=0",
                  value, index, wrap);
      end
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (index !== 4'd6) begin
         failures++;
         $display("FAIL idle_hold got=%0d exp=6", index);
      end
      load = 1'b0;
      enable = 1'b1; mode = 2'b11;
      tick();
      checks++;
      if (value !== 16'h0040 || index !== 4'd6) begin
         failures++;
         $display("FAIL reenable_hold got v=%h i=%0d exp v=0040 i=6",
                  value, index);
      end
      mode = 2'b01;
      tick();
      for (int c = 0; c < 4; c++) tick();
      checks++;
      if (index !== 4'd6) begin
         failures++;
         $display("FAIL resume_wait got=%0d exp=6", index);
      end
      tick();
      checks++;
      if (index !== 4'd7 || value !== 16'h0080) begin
         failures++;
         $display("FAIL resume_step got i=%0d v=%h exp i=7 v=0080",
                  index, value);
      end
   endtask

   task automatic test_reset_mid_scan();
      load = 1'b1; binary_in = 4'd11;
      tick();
      load = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (index !== 4'd0 || value !== 16'h0000 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got i=%0d v=%h w=%b exp i=0 v=0000 w=0",
                  index, value, wrap);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (index !== 4'd0 || value !== 16'h0001) begin
         failures++;
         $display("FAIL post_reset got i=%0d v=%h exp i=0 v=0001",
                  index, value);
      end
      for (int c = 0; c < 4; c++) tick();
      checks++;
      if (index !== 4'd0) begin
         failures++;
         $display("FAIL post_reset_wait got=%0d exp=0", index);
      end
      tick();
      checks++;
      if (index !== 4'd1 || value !== 16'h0002) begin
         failures++;
         $display("FAIL post_reset_step got i=%0d v=%h exp i=1 v=0002",
                  index, value);
      end
   endtask

   task automatic test_sweep_div1();
      logic [1:0] exp_i [5];
      logic       exp_w [5];
      exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      e2 = 1'b1; m2 = 2'b01;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (i2 !== exp_i[c] || w2 !== exp_w[c] ||
             v2 !== (4'b0001 << exp_i[c])) begin
            failures++;
            $display("FAIL sweep_cyc%0d got i=%0d w=%b v=%b exp i=%0d w=%b",
                     c, i2, w2, v2, exp_i[c], exp_w[c]);
         end
      end
      tick();
      checks++;
      if (i2 !== 2'd1 || w2 !== 1'b0) begin
         failures++;
         $display("FAIL sweep_after got i=%0d w=%b exp i=1 w=0", i2, w2);
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan_up();
      test_scan_down();
      test_hold();
      test_enable_drop();
      test_reset_mid_scan();
      test_sweep_div1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
